// File: rtl/rx_frame_check_if.sv
// -----------------------------------------------------------------------------
// rx_frame_check_if
// Host-side handshake bundle of the receive frame checker.
//   RxValid   : head entry present (FIFO not empty)
//   RxData    : head byte, D7..D0
//   StartErr  : head entry start bit was 1
//   StopErr   : head entry stop bit was 0
//   ParityErr : head entry parity mismatch
//   RxReady   : host accepts the head entry this cycle
// Modports: master = checker side (drives the entry), slave = host side.
// -----------------------------------------------------------------------------
interface rx_frame_check_if;
    logic       RxValid;
    logic [7:0] RxData;
    logic       StartErr;
    logic       StopErr;
    logic       ParityErr;
    logic       RxReady;

    modport master (
        output RxValid,
        output RxData,
        output StartErr,
        output StopErr,
        output ParityErr,
        input  RxReady
    );

    modport slave (
        input  RxValid,
        input  RxData,
        input  StartErr,
        input  StopErr,
        input  ParityErr,
        output RxReady
    );
endinterface

// File: rtl/rx_frame_check.sv
// -----------------------------------------------------------------------------
// rx_frame_check
// Receive-path stage after the serial-in/parallel-out shift register.
// Synchronises the BaudOut-domain frame-complete flag into Clk, detects its
// rising edge, decodes the 11-bit frame {start, D0..D7, parity, stop}, and
// queues {StopErr, StartErr, ParityErr, byte} into a show-ahead FIFO that the
// host drains through a valid/ready handshake.
//
// Ports:
//   Clk          : system clock
//   ResetN       : asynchronous assert, active-low reset
//   RecievedFlag : frame-complete level, BaudOut domain
//   DataParl     : [10]=start, [9]=D0 .. [2]=D7, [1]=parity, [0]=stop
//   OvrClr       : clears the sticky Overrun flag
//   Overrun      : sticky, a frame was dropped because the FIFO was full
//   Level        : current FIFO occupancy (0..FIFO_DEPTH)
//   host         : rx_frame_check_if.master (RxValid/RxData/errors/RxReady)
//
// Build option: RX_PARITY_CHECK_EN
//   defined   -> ParityErr = (^DataParl[9:1]) != PARITY_ODD
//   undefined -> parity bit ignored, ParityErr is always 0, PARITY_ODD unused
// -----------------------------------------------------------------------------
module rx_frame_check #(
    parameter bit PARITY_ODD = 1'b0,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              RecievedFlag,
    input  logic [10:0]       DataParl,
    input  logic              OvrClr,
    output logic              Overrun,
    output logic [PTR_W:0]    Level,
    rx_frame_check_if.master  host
);

    // ---------------------------------------------------------------
    // Flag synchroniser and rising-edge detect
    // ---------------------------------------------------------------
    logic       sync1_q;
    logic       sync2_q;
    logic       hist_q;
    logic       hist_d;
    logic [1:0] fill_q;
    logic       capture;

    // The history flop is held at 1 until the two-flop chain has refilled
    // after reset. Otherwise the zeros shifted out of the chain would
    // clear it and a flag that was already high at release would be
    // mistaken for a fresh rising edge.
    assign hist_d  = fill_q[1] ? sync2_q : 1'b1;
    assign capture = sync2_q & ~hist_q;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b1;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= RecievedFlag;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

    // ---------------------------------------------------------------
    // Frame decode (DataParl is stable while the flag is high)
    // ---------------------------------------------------------------
    logic [7:0]  frame_byte;
    logic        start_err;
    logic        stop_err;
    logic        parity_err;
    logic [10:0] entry;

    // D0 arrives first and sits at the top of the frame; reverse it so
    // D7 becomes the MSB of the byte.
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte
        assign frame_byte[gi] = DataParl[9 - gi];
    end

    assign start_err = DataParl[10];
    assign stop_err  = ~DataParl[0];

`ifdef RX_PARITY_CHECK_EN
    assign parity_err = (^DataParl[9:1]) != PARITY_ODD;
`else
    logic unused_parity;
    assign unused_parity = DataParl[1] ^ PARITY_ODD;
    assign parity_err    = 1'b0;
`endif

    assign entry = {stop_err, start_err, parity_err, frame_byte};

    // ---------------------------------------------------------------
    // FIFO control
    // ---------------------------------------------------------------
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] wptr_d;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] rptr_d;
    logic [PTR_W:0]   level_q;
    logic [PTR_W:0]   level_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             valid;
    logic             full;
    logic             pop;
    logic             push;
    logic             overflow;

    assign valid    = (level_q != '0);
    assign full     = (level_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop      = valid & host.RxReady;
    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign push     = capture & (~full | pop);
    assign overflow = capture & full & ~pop;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (PTR_W + 1)'(1);
            2'b01:   level_d = level_q - (PTR_W + 1)'(1);
            default: level_d = level_q;
        endcase
        // A drop in the same cycle as a clear request keeps the flag set.
        if (overflow) begin
            overrun_d = 1'b1;
        end else if (OvrClr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    // ---------------------------------------------------------------
    // Storage: written on push, read combinationally at the head
    // ---------------------------------------------------------------
    logic [10:0] mem_q [FIFO_DEPTH];
    logic [10:0] head;

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wptr_q] <= entry;
        end
    end

    assign head = mem_q[rptr_q];

    // Entry fields are forced to 0 while empty so stale storage never leaks.
    assign host.RxValid   = valid;
    assign host.RxData    = valid ? head[7:0] : 8'h00;
    assign host.ParityErr = valid & head[8];
    assign host.StartErr  = valid & head[9];
    assign host.StopErr   = valid & head[10];

    assign Overrun = overrun_q;
    assign Level   = level_q;

endmodule

// File: tb/tb_rx_frame_check.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_check
// Table of single frames (decode and error flags), then hand-written
// sequences for overflow, full-with-pop, and reset with the flag held high.
// Expected entries are pushed on a scoreboard queue when a frame is driven
// and popped when the host side accepts the head entry.
// -----------------------------------------------------------------------------
module tb_rx_frame_check;
    localparam int DEPTH = 4;
    localparam int PW    = 2;
`ifdef RX_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef struct packed {
        logic       sp;
        logic       st;
        logic       pe;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        logic [10:0] frame;
        exp_t        exp;
        string       name;
    } vec_t;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        RecievedFlag = 1'b0;
    logic [10:0] DataParl = '0;
    logic        OvrClr = 1'b0;
    logic        Overrun;
    logic [PW:0] Level;

    rx_frame_check_if rxif ();

    rx_frame_check #(
        .PARITY_ODD (1'b0),
        .FIFO_DEPTH (DEPTH),
        .PTR_W      (PW)
    ) dut (
        .Clk          (Clk),
        .ResetN       (ResetN),
        .RecievedFlag (RecievedFlag),
        .DataParl     (DataParl),
        .OvrClr       (OvrClr),
        .Overrun      (Overrun),
        .Level        (Level),
        .host         (rxif)
    );

    always #5 Clk = ~Clk;

    exp_t sb_q[$];
    bit   m_ovr = 1'b0;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end else begin
            $display("[TB] ok   %s = %0h", nm, act);
        end
    endtask

    // Build a frame from a byte; pflip inverts the (even) parity bit.
    function automatic logic [10:0] mk(input logic [7:0] b, input logic st,
                                       input logic sp, input logic pflip);
        logic [10:0] f;
        f[10] = st;
        for (int i = 0; i < 8; i++) f[9 - i] = b[i];
        f[1] = (^b) ^ pflip;
        f[0] = ~sp;
        return f;
    endfunction

    // Drive one flag pulse; lat = negedge count from rise to RxValid when
    // the FIFO was empty (0 if it never showed up within the pulse).
    task automatic send(input logic [10:0] f, input exp_t e, output int lat);
        bit was_empty;
        was_empty = (sb_q.size() == 0);
        if (sb_q.size() < DEPTH) sb_q.push_back(e);
        else m_ovr = 1'b1;
        lat = 0;
        @(posedge Clk); #1;
        DataParl     = f;
        RecievedFlag = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clk);
            if (lat == 0 && was_empty && rxif.RxValid) lat = i;
        end
        @(posedge Clk); #1;
        RecievedFlag = 1'b0;
        repeat (3) @(posedge Clk);
    endtask

    task automatic pop_check(input string nm);
        int n;
        n = 0;
        @(negedge Clk);
        while (!rxif.RxValid && n < 10) begin
            @(negedge Clk);
            n++;
        end
        if (!rxif.RxValid) begin
            tests++;
            fails++;
            $display("FAIL %s: RxValid got 0 after 10 cycles, expected 1", nm);
        end else if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got entry %0h, expected none", nm, rxif.RxData);
        end else begin
            exp_t e;
            e = sb_q.pop_front();
            check(nm, {rxif.StopErr, rxif.StartErr, rxif.ParityErr, rxif.RxData}, e);
            rxif.RxReady = 1'b1;
            @(posedge Clk); #1;
            rxif.RxReady = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   lat;
        exp_t e;

        tbl[0] = '{11'h295, '{1'b0, 1'b0, 1'b0, 8'hA5}, "even_ok_A5"};
        tbl[1] = '{11'h297, '{1'b0, 1'b0, PCHK, 8'hA5}, "parity_flip_A5"};
        tbl[2] = '{11'h294, '{1'b1, 1'b0, 1'b0, 8'hA5}, "stop_err_A5"};
        tbl[3] = '{11'h695, '{1'b0, 1'b1, 1'b0, 8'hA5}, "start_err_A5"};
        tbl[4] = '{11'h001, '{1'b0, 1'b0, 1'b0, 8'h00}, "byte_00"};
        tbl[5] = '{11'h3FD, '{1'b0, 1'b0, 1'b0, 8'hFF}, "byte_FF"};
        tbl[6] = '{11'h203, '{1'b0, 1'b0, 1'b0, 8'h01}, "byte_01_d0"};
        tbl[7] = '{11'h7FC, '{1'b1, 1'b1, 1'b0, 8'hFF}, "start_stop_FF"};

        // Reset state
        rxif.RxReady = 1'b0;
        ResetN = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_valid", rxif.RxValid, 0);
        check("rst_data", rxif.RxData, 0);
        check("rst_errs", {rxif.StopErr, rxif.StartErr, rxif.ParityErr}, 0);
        check("rst_level", Level, 0);
        check("rst_overrun", Overrun, 0);
        ResetN = 1'b1;
        repeat (4) @(posedge Clk);

        // Table-driven single frames
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].frame, tbl[i].exp, lat);
            if (i == 0) check("latency_3to4", (lat >= 3 && lat <= 4), 1);
            @(negedge Clk);
            check({tbl[i].name, "_level"}, Level, 1);
            pop_check(tbl[i].name);
            @(negedge Clk);
            check({tbl[i].name, "_empty"}, rxif.RxValid, 0);
        end

        // Overflow: five frames, no draining
        for (int b = 1; b <= 5; b++) begin
            e = '{1'b0, 1'b0, 1'b0, 8'(b)};
            send(mk(8'(b), 1'b0, 1'b0, 1'b0), e, lat);
        end
        @(negedge Clk);
        check("ovf_level", Level, 4);
        check("ovf_overrun", Overrun, 1);
        for (int k = 0; k < 4; k++) pop_check("ovf_drain");
        @(negedge Clk);
        check("ovf_drained", rxif.RxValid, 0);
        check("ovf_sticky", Overrun, 1);
        @(posedge Clk); #1;
        OvrClr = 1'b1;
        @(posedge Clk); #1;
        OvrClr = 1'b0;
        m_ovr = 1'b0;
        @(negedge Clk);
        check("ovf_cleared", Overrun, 0);

        // Full FIFO with a pop coinciding with the capture cycle
        for (int b = 'h10; b <= 'h13; b++) begin
            e = '{1'b0, 1'b0, 1'b0, 8'(b)};
            send(mk(8'(b), 1'b0, 1'b0, 1'b0), e, lat);
        end
        @(posedge Clk); #1;
        DataParl     = mk(8'h14, 1'b0, 1'b0, 1'b0);
        RecievedFlag = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;            // now in the capture cycle
        rxif.RxReady = 1'b1;
        @(negedge Clk);
        e = sb_q.pop_front();
        check("full_pop_head", {rxif.StopErr, rxif.StartErr, rxif.ParityErr, rxif.RxData}, e);
        sb_q.push_back('{1'b0, 1'b0, 1'b0, 8'h14});
        @(posedge Clk); #1;
        rxif.RxReady = 1'b0;
        @(negedge Clk);
        check("full_pop_level", Level, 4);
        check("full_pop_no_ovr", Overrun, 0);
        repeat (2) @(posedge Clk);
        #1;
        RecievedFlag = 1'b0;
        repeat (3) @(posedge Clk);
        for (int k = 0; k < 4; k++) pop_check("full_pop_drain");

        // Reset mid-operation with the flag held high across release
        for (int b = 'h21; b <= 'h23; b++) begin
            e = '{1'b0, 1'b0, 1'b0, 8'(b)};
            send(mk(8'(b), 1'b0, 1'b0, 1'b0), e, lat);
        end
        @(negedge Clk);
        check("mid_level3", Level, 3);
        @(posedge Clk); #1;
        DataParl     = mk(8'h30, 1'b0, 1'b0, 1'b0);
        RecievedFlag = 1'b1;
        @(posedge Clk); #2;
        ResetN = 1'b0;
        #1;
        check("mid_rst_valid", rxif.RxValid, 0);
        check("mid_rst_data", rxif.RxData, 0);
        check("mid_rst_level", Level, 0);
        sb_q.delete();
        m_ovr = 1'b0;
        @(posedge Clk); #1;
        ResetN = 1'b1;
        repeat (8) @(negedge Clk);
        check("held_flag_ignored", {rxif.RxValid, Level}, 0);
        @(posedge Clk); #1;
        RecievedFlag = 1'b0;
        repeat (4) @(posedge Clk);
        send(mk(8'h5A, 1'b0, 1'b0, 1'b0), '{1'b0, 1'b0, 1'b0, 8'h5A}, lat);
        check("rerise_latency", (lat >= 3 && lat <= 4), 1);
        pop_check("rerise_5A");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
